// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch vs. load/store) in front of the single data SRAM port.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority, data over fetch.
module mem_arbiter #(
  parameter int         XLEN       = 32,
  parameter logic [2:0] IF_RD_CTRL = 3'b010
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  input  logic [XLEN-1:0] if_req_addr,
  output logic            if_req_ready,
  output logic            if_resp_valid,
  output logic [XLEN-1:0] if_resp_data,
  input  logic            d_req_valid,
  input  logic [2:0]      d_req_rd_ctrl,
  input  logic [1:0]      d_req_wr_ctrl,
  input  logic [XLEN-1:0] d_req_addr,
  input  logic [XLEN-1:0] d_req_wdata,
  output logic            d_req_ready,
  output logic            d_resp_valid,
  output logic [XLEN-1:0] d_resp_data,
  output logic [2:0]      sram_rd_ctrl,
  output logic [1:0]      sram_wr_ctrl,
  output logic [XLEN-1:0] sram_addr,
  output logic [XLEN-1:0] sram_wdata,
  input  logic [XLEN-1:0] sram_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e          state_q, state_d;
  logic            win_data_q, win_data_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      rd_ctrl_q, rd_ctrl_d;
  logic [1:0]      wr_ctrl_q, wr_ctrl_d;
  logic            grant_d, grant_if;
  logic            can_accept;

`ifdef MEM_ARB_RR_EN
  // High when the most recent handshake went to the data port.
  logic            last_data_q, last_data_d;
`endif

  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (d_req_valid && if_req_valid) begin
      grant_d  = ~last_data_q;
      grant_if = last_data_q;
    end else begin
      grant_d  = d_req_valid;
      grant_if = if_req_valid;
    end
`else
    grant_d  = d_req_valid;
    grant_if = if_req_valid & ~d_req_valid;
`endif
  end

  assign can_accept   = ~rst & ((state_q == IDLE) | (state_q == RESP));
  assign d_req_ready  = can_accept & grant_d;
  assign if_req_ready = can_accept & grant_if;

  always_comb begin
    state_d    = state_q;
    win_data_d = win_data_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_ctrl_d  = rd_ctrl_q;
    wr_ctrl_d  = wr_ctrl_q;
`ifdef MEM_ARB_RR_EN
    last_data_d = last_data_q;
`endif
    case (state_q)
      IDLE:    state_d = (d_req_ready || if_req_ready) ? ISSUE : IDLE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = (d_req_ready || if_req_ready) ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
    // Fetches are latched with their fixed read code so ISSUE can drive straight from the latch.
    if (d_req_ready) begin
      win_data_d = 1'b1;
      addr_d     = d_req_addr;
      wdata_d    = d_req_wdata;
      rd_ctrl_d  = d_req_rd_ctrl;
      wr_ctrl_d  = d_req_wr_ctrl;
    end else if (if_req_ready) begin
      win_data_d = 1'b0;
      addr_d     = if_req_addr;
      wdata_d    = '0;
      rd_ctrl_d  = IF_RD_CTRL;
      wr_ctrl_d  = 2'b00;
    end
`ifdef MEM_ARB_RR_EN
    if (d_req_ready || if_req_ready) begin
      last_data_d = d_req_ready;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_data_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_ctrl_q  <= 3'b000;
      wr_ctrl_q  <= 2'b00;
`ifdef MEM_ARB_RR_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      win_data_q <= win_data_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_ctrl_q  <= rd_ctrl_d;
      wr_ctrl_q  <= wr_ctrl_d;
`ifdef MEM_ARB_RR_EN
      last_data_q <= last_data_d;
`endif
    end
  end

  // Outputs are forced quiet while rst is high so an in-flight response is dropped immediately.
  always_comb begin
    busy          = 1'b0;
    sram_rd_ctrl  = 3'b000;
    sram_wr_ctrl  = 2'b00;
    sram_addr     = '0;
    sram_wdata    = '0;
    if_resp_valid = 1'b0;
    if_resp_data  = '0;
    d_resp_valid  = 1'b0;
    d_resp_data   = '0;
    if (!rst) begin
      case (state_q)
        ISSUE: begin
          busy         = 1'b1;
          sram_rd_ctrl = rd_ctrl_q;
          sram_wr_ctrl = wr_ctrl_q;
          sram_addr    = addr_q;
          sram_wdata   = wdata_q;
        end
        RESP: begin
          if (win_data_q) begin
            d_resp_valid = 1'b1;
            d_resp_data  = sram_rdata;
          end else begin
            if_resp_valid = 1'b1;
            if_resp_data  = sram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single data SRAM port of the `mem` model between instruction fetch (IF) and load/store (EXE).
- Each requester uses a valid/ready request channel and a fixed-latency response pulse.
- The block registers the winning request, drives the SRAM control/address/data for exactly one cycle, then returns read data to the winner.
- It sits between `if_stage`/`exe_stage` and `mem` inside `cpu`.

## Interface
Parameters:
- `XLEN`, 32, data/address width.
- `IF_RD_CTRL`, 3'b010, `rd_ctrl` code driven for fetches (full-word read).

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req_valid`  in  1  fetch request.
- `if_req_addr`  in  XLEN  fetch address.
- `if_req_ready`  out  1  fetch request accepted this cycle when high together with valid.
- `if_resp_valid`  out  1  one-cycle pulse, fetch data valid.
- `if_resp_data`  out  XLEN  fetched instruction word.
- `d_req_valid`  in  1  data request.
- `d_req_rd_ctrl`  in  3  load control; 0 means no read.
- `d_req_wr_ctrl`  in  2  store control; 0 means no write.
- `d_req_addr`  in  XLEN  data address.
- `d_req_wdata`  in  XLEN  store data.
- `d_req_ready`  out  1  data request accepted.
- `d_resp_valid`  out  1  one-cycle pulse: load data valid or store acknowledged.
- `d_resp_data`  out  XLEN  load data; undefined for stores.
- `sram_rd_ctrl`  out  3  to `mem.data_sram_rd_ctrl`.
- `sram_wr_ctrl`  out  2  to `mem.data_sram_wr_ctrl`.
- `sram_addr`  out  XLEN  to `mem.data_sram_addr`.
- `sram_wdata`  out  XLEN  to `mem.data_sram_wdata`.
- `sram_rdata`  in  XLEN  from `mem.data_sram_rdata`; valid the cycle after the read is driven.
- `busy`  out  1  high in ISSUE.

## Operation
- States: IDLE, ISSUE, RESP.
- Ready rules:
  - Readies are high only in IDLE or RESP, never while `rst` is high, and only for the arbitration winner.
  - At most one ready is high per cycle.
- Transitions:
  - IDLE or RESP with a handshake: latch winner id, addr, ctrl and wdata; go to ISSUE.
  - RESP with no handshake: go to IDLE.
  - ISSUE always goes to RESP.
- ISSUE drives the SRAM from the latched request:
  - fetch: `rd_ctrl=IF_RD_CTRL`, `wr_ctrl=0`, `wdata=0`.
  - data: the latched ctrl, addr and wdata.
- Outside ISSUE, all `sram_*` outputs are 0.
- RESP:
  - Asserts exactly one of `if_resp_valid`/`d_resp_valid` per the latched winner.
  - The response data output is `sram_rdata` passed through; the other response data output is 0.
  - Requesters cannot stall responses.
- Default arbitration: fixed priority, data over fetch.
- A data request with both ctrls 0 is accepted and acknowledged normally; the SRAM sees no operation.
- Requesters hold valid and payload stable until ready; the block does not check this.

## Timing
- Handshake at edge ending cycle N → SRAM driven in cycle N+1 → response pulse in cycle N+2.
- Back-to-back throughput: one request per 2 cycles. A request accepted in RESP is issued the next cycle.
- Stores are written at the edge ending the ISSUE cycle, and are visible to a load issued one transaction later.
- Reset (any state):
  - Next state IDLE.
  - Latched request cleared; any in-flight response is dropped (no pulse).
  - Arbitration pointer reset.
  - Outputs during and after reset until the next handshake: all `sram_*`, resp valids, resp data, readies and `busy` = 0.
- A request arriving during ISSUE waits; readies are 0 in ISSUE.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit last-grant register, reset to "fetch".
  - On simultaneous requests the requester not granted last wins, so contention alternates, starting with data.
  - The register updates on every handshake, including uncontended ones.
- `MEM_ARB_RR_EN` undefined: fixed priority, data over fetch; a continuous data stream starves fetch.

## Test plan
- Single fetch from IDLE, addr 0x100, `sram_rdata`=0x00500093 in cycle N+2 → `sram_addr`=0x100 and `rd_ctrl`=`IF_RD_CTRL` in N+1 only; `if_resp_valid`=1 with data 0x00500093 in N+2 only.
- Store `wr_ctrl`=2'b11 to 0x200 with wdata 0xDEADBEEF, then load 0x200 → the store drives the SRAM for one cycle with `rd_ctrl`=0 and `d_resp_valid` pulses; the load returns 0xDEADBEEF 2 cycles after its handshake.
- Both valid continuously for 8 transactions:
  - macro undefined → all 8 grants to data, no `if_req_ready`.
  - `MEM_ARB_RR_EN` defined → grants alternate D,F,D,F,…
- Back-to-back fetches 0x0, 0x4, 0x8 held valid → handshakes in cycles 0, 2, 4; responses in 2, 4, 6; `busy` high in 1, 3, 5.
- Assert `rst` during ISSUE of a load → no `d_resp_valid` in the following cycle; all outputs 0; the next request after reset completes normally.
- Data request with both ctrls 0 → `d_resp_valid` pulse at N+2; `sram_rd_ctrl`/`sram_wr_ctrl` stay 0 throughout.
